regfile_mr1w: RTL and testbench

// - Parametrised successor of the single-port integer register file: NUM_READ synchronous read ports, one write port.
// - Adds hardwired-zero register 0, write-first bypass on every read port, and a hardware clear sequencer.
// - The clear sequencer replaces $readmemh initialisation.
// - Sits in the ID stage of the RV32IC pipeline: feeds rs1/rs2 operands; the WB stage drives the write port.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_clear_seq.sv | 59 +++++
 rtl/regfile_mr1w.sv | 91 +++++++++
 tb/tb_regfile_mr1w.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-read / single-write register file.
//   rf_state_e : clear-sequencer FSM states
//   RF_ADDR_W, RF_DATA_W, RF_NREGS : default port geometry (RV32 integer file)
//   rf_data_t  : default-width register word
package regfile_pkg;

   typedef enum logic {RF_CLEAR, RF_READY} rf_state_e;

   localparam int RF_ADDR_W = 5;
   localparam int RF_DATA_W = 32;
   localparam int RF_NREGS  = 32;

   typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: after reset, sweeps every implemented entry once, writing 0,
// then parks in READY until the next reset.
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   clr_we    out  1 while the sweep owns the RAM write port
//   clr_addr  out  entry being cleared this cycle
//   init_busy out  1 for the whole sweep (CLEAR state decode)
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = RF_NREGS
) (
   input  logic                        clk,
   input  logic                        rst,
   output logic                        clr_we,
   output logic [$clog2(NUM_REGS)-1:0] clr_addr,
   output logic                        init_busy
);

   localparam int                CNT_W = $clog2(NUM_REGS);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(NUM_REGS - 1);

   rf_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RF_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr_we  = 1'b0;
      case (state_q)
         RF_CLEAR: begin
            // A reset cycle restarts the sweep, so it must not count as a clear.
            clr_we = !rst;
            if (cnt_q == LAST) begin
               // Counter holds on the last entry; it never wraps.
               state_d = RF_READY;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RF_READY: ;
         default: state_d = RF_CLEAR;
      endcase
   end

   assign clr_addr  = cnt_q;
   assign init_busy = (state_q == RF_CLEAR);

endmodule

// File: rtl/regfile_mr1w.sv
// Register file with NUM_READ registered read ports and one write port.
// Optional hardwired-zero entry 0, write-first bypass on every read port, and a
// hardware clear sweep after reset.
//   clk, rst        clock, synchronous active-high reset
//   we, write_addr, din   write port (ignored while init_busy)
//   read_addr[i]    read index per port, sampled each edge
//   dout[i]         read data, one cycle after read_addr[i]
//   init_busy       1 while the clear sweep is running
module regfile_mr1w
   import regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = RF_ADDR_W,
   parameter int DATA_WIDTH = RF_DATA_W,
   parameter int NUM_REGS   = RF_NREGS,
   parameter int NUM_READ   = 2,
   parameter int ZERO_REG   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic [ADDR_WIDTH-1:0] read_addr [NUM_READ],
   output logic [DATA_WIDTH-1:0] dout      [NUM_READ],
   output logic                  init_busy
);

   localparam int                  IDX_W     = $clog2(NUM_REGS);
   // One extra bit so NUM_REGS == 2**ADDR_WIDTH is representable.
   localparam logic [ADDR_WIDTH:0] NREGS_EXT = (ADDR_WIDTH + 1)'(NUM_REGS);

   logic [DATA_WIDTH-1:0] ram [NUM_REGS];

   logic             clr_we;
   logic [IDX_W-1:0] clr_addr;
   logic             busy;

   regfile_clear_seq #(
      .NUM_REGS (NUM_REGS)
   ) u_clear_seq (
      .clk       (clk),
      .rst       (rst),
      .clr_we    (clr_we),
      .clr_addr  (clr_addr),
      .init_busy (busy)
   );

   assign init_busy = busy;

   // Port write is accepted only in READY, in range, and not to a hardwired zero.
   logic             wr_ok;
   logic [IDX_W-1:0] wr_idx;

   assign wr_ok  = we && !rst && !busy
                   && ({1'b0, write_addr} < NREGS_EXT)
                   && !((ZERO_REG != 0) && (write_addr == '0));
   assign wr_idx = write_addr[IDX_W-1:0];

   // Sweep and port never overlap in practice (wr_ok needs !busy); sweep wins anyway.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         ram[clr_addr] <= '0;
      end else if (wr_ok) begin
         ram[wr_idx] <= din;
      end
   end

   logic [DATA_WIDTH-1:0] rd_d [NUM_READ];

   for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
      logic [IDX_W-1:0] rd_idx;
      logic             rd_zero, rd_oor, rd_hit;

      assign rd_idx  = read_addr[g][IDX_W-1:0];
      assign rd_zero = (ZERO_REG != 0) && (read_addr[g] == '0);
      assign rd_oor  = ({1'b0, read_addr[g]} >= NREGS_EXT);
      assign rd_hit  = wr_ok && (write_addr == read_addr[g]);
      // Zero/out-of-range first, then write-first bypass, then array.
      assign rd_d[g] = (rd_zero || rd_oor) ? '0  :
                       rd_hit              ? din :
                                             ram[rd_idx];
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_READ; i++) begin
         if (rst || busy) dout[i] <= '0;
         else             dout[i] <= rd_d[i];
      end
   end

endmodule

// File: tb/tb_regfile_mr1w.sv
module tb_regfile_mr1w;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we = 1'b0;
   logic [4:0]  write_addr = '0;
   logic [31:0] din = '0;
   logic [4:0]  read_addr [2];
   logic [31:0] dout_d [2];
   logic [31:0] dout_z [2];
   logic [31:0] dout_s [2];
   logic        busy_d, busy_z, busy_s;

   always #5 clk = ~clk;

   // default configuration
   regfile_mr1w dut (
      .clk(clk), .rst(rst), .we(we), .write_addr(write_addr), .din(din),
      .read_addr(read_addr), .dout(dout_d), .init_busy(busy_d));

   // entry 0 ordinary
   regfile_mr1w #(.ZERO_REG(0)) dut_z0 (
      .clk(clk), .rst(rst), .we(we), .write_addr(write_addr), .din(din),
      .read_addr(read_addr), .dout(dout_z), .init_busy(busy_z));

   // 16 entries behind a 5-bit index
   regfile_mr1w #(.NUM_REGS(16)) dut_16 (
      .clk(clk), .rst(rst), .we(we), .write_addr(write_addr), .din(din),
      .read_addr(read_addr), .dout(dout_s), .init_busy(busy_s));

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      string       name;
      int          inst;
      int          port;
      logic [31:0] exp;
   } sb_t;
   sb_t sbq[$];

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] din;
      logic [4:0]  ra0, ra1;
      logic [31:0] ed0, ed1, ez0, ez1, es0, es1;
   } vec_t;
   vec_t vecs[12];

   function automatic vec_t mk(logic w, logic [4:0] wa, logic [31:0] d,
                               logic [4:0] r0, logic [4:0] r1,
                               logic [31:0] d0, logic [31:0] d1,
                               logic [31:0] z0, logic [31:0] z1,
                               logic [31:0] s0, logic [31:0] s1);
      vec_t v;
      v.we = w; v.wa = wa; v.din = d; v.ra0 = r0; v.ra1 = r1;
      v.ed0 = d0; v.ed1 = d1; v.ez0 = z0; v.ez1 = z1; v.es0 = s0; v.es1 = s1;
      return v;
   endfunction

   function automatic logic [31:0] get_dout(int inst, int port);
      case (inst)
         0:       return dout_d[port];
         1:       return dout_z[port];
         default: return dout_s[port];
      endcase
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push6(string name, logic [31:0] d0, logic [31:0] d1,
                        logic [31:0] z0, logic [31:0] z1,
                        logic [31:0] s0, logic [31:0] s1);
      sbq.push_back('{name, 0, 0, d0});
      sbq.push_back('{name, 0, 1, d1});
      sbq.push_back('{name, 1, 0, z0});
      sbq.push_back('{name, 1, 1, z1});
      sbq.push_back('{name, 2, 0, s0});
      sbq.push_back('{name, 2, 1, s1});
   endtask

   // Advance one edge and compare everything queued for it.
   task automatic cycle_and_drain();
      sb_t e;
      @(posedge clk); #1;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         check($sformatf("%s/i%0d/p%0d", e.name, e.inst, e.port),
               get_dout(e.inst, e.port), e.exp);
      end
   endtask

   // Counts edges after rst falls until each init_busy drops; dout must be 0 meanwhile.
   // we is dropped after the 5th edge so early sweep cycles see write attempts.
   task automatic sweep_check(string name, int exp_big, int exp_small);
      int kd, kz, ks, bad;
      kd = -1; kz = -1; ks = -1; bad = 0;
      for (int k = 1; k <= 64; k++) begin
         @(posedge clk); #1;
         if (k == 5) we = 1'b0;
         if (kd < 0) begin
            if (!busy_d) kd = k;
            else if (dout_d[0] !== '0 || dout_d[1] !== '0) bad++;
         end
         if (kz < 0) begin
            if (!busy_z) kz = k;
            else if (dout_z[0] !== '0 || dout_z[1] !== '0) bad++;
         end
         if (ks < 0) begin
            if (!busy_s) ks = k;
            else if (dout_s[0] !== '0 || dout_s[1] !== '0) bad++;
         end
         if (kd >= 0 && kz >= 0 && ks >= 0) break;
      end
      check({name, "_busy_cycles_def"}, kd, exp_big);
      check({name, "_busy_cycles_z0"},  kz, exp_big);
      check({name, "_busy_cycles_n16"}, ks, exp_small);
      check({name, "_dout_zero"},       bad, 0);
   endtask

   initial begin
      vecs[0]  = mk(1, 5,  32'hDEADBEEF, 0,  0,  0, 0, 0, 0, 0, 0);
      vecs[1]  = mk(0, 5,  32'h0,        5,  6,  32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0);
      vecs[2]  = mk(1, 7,  32'h12345678, 7,  7,  32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678,
                    32'h12345678, 32'h12345678);
      vecs[3]  = mk(1, 0,  32'hFFFFFFFF, 0,  5,  0, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF, 0, 32'hDEADBEEF);
      vecs[4]  = mk(0, 0,  32'h0,        0,  7,  0, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 0, 32'h12345678);
      vecs[5]  = mk(1, 31, 32'h1F,       31, 30, 32'h1F, 0, 32'h1F, 0, 0, 0);
      vecs[6]  = mk(1, 5,  32'h55,       5,  5,  32'h55, 32'h55, 32'h55, 32'h55, 32'h55, 32'h55);
      vecs[7]  = mk(0, 5,  32'h99,       5,  31, 32'h55, 32'h1F, 32'h55, 32'h1F, 32'h55, 0);
      vecs[8]  = mk(1, 4,  32'h44,       4,  3,  32'h44, 0, 32'h44, 0, 32'h44, 0);
      vecs[9]  = mk(1, 20, 32'hCAFEF00D, 20, 4,  32'hCAFEF00D, 32'h44, 32'hCAFEF00D, 32'h44, 0, 32'h44);
      vecs[10] = mk(0, 20, 32'h0,        20, 4,  32'hCAFEF00D, 32'h44, 32'hCAFEF00D, 32'h44, 0, 32'h44);
      vecs[11] = mk(0, 0,  32'h0,        7,  5,  32'h12345678, 32'h55, 32'h12345678, 32'h55,
                    32'h12345678, 32'h55);

      read_addr[0] = '0;
      read_addr[1] = '0;

      // reset held for 3 cycles
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy_def", {31'b0, busy_d}, 1);
      check("rst_busy_z0",  {31'b0, busy_z}, 1);
      check("rst_busy_n16", {31'b0, busy_s}, 1);
      check("rst_dout_def0", dout_d[0], 0);
      check("rst_dout_def1", dout_d[1], 0);
      check("rst_dout_z0",   dout_z[0], 0);
      check("rst_dout_n16",  dout_s[1], 0);

      rst = 1'b0;
      sweep_check("sweep", 32, 16);

      // every entry reads 0 after the sweep
      for (int a = 0; a < 32; a += 2) begin
         read_addr[0] = 5'(a);
         read_addr[1] = 5'(a + 1);
         push6($sformatf("zero_rd%0d", a), 0, 0, 0, 0, 0, 0);
         cycle_and_drain();
      end

      // table-driven write/read/bypass/zero-register/out-of-range vectors
      for (int i = 0; i < 12; i++) begin
         we           = vecs[i].we;
         write_addr   = vecs[i].wa;
         din          = vecs[i].din;
         read_addr[0] = vecs[i].ra0;
         read_addr[1] = vecs[i].ra1;
         push6($sformatf("vec%0d", i), vecs[i].ed0, vecs[i].ed1, vecs[i].ez0,
               vecs[i].ez1, vecs[i].es0, vecs[i].es1);
         cycle_and_drain();
      end

      // reset in the middle of a sweep, with a write attempted during CLEAR
      we = 1'b1; write_addr = 5'd3; din = 32'hA5A5A5A5;
      read_addr[0] = 5'd5; read_addr[1] = 5'd3;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("mid_busy_before_rst", {31'b0, busy_d}, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sweep_check("mid", 32, 16);
      we = 1'b0;
      read_addr[0] = 5'd3; read_addr[1] = 5'd5;
      push6("mid_rd", 0, 0, 0, 0, 0, 0);
      cycle_and_drain();
      read_addr[0] = 5'd4; read_addr[1] = 5'd20;
      push6("mid_rd2", 0, 0, 0, 0, 0, 0);
      cycle_and_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

endmodule
